ftb_assoc: RTL and testbench

- Parametrised set-associative Fetch Target Buffer; successor to the single-entry-format FTB.
- Generalises set count, way count, tag, target, fallthrough and counter widths.
- Target encoding uses a full-width high-part compare: FIT/OVF/UDF, plus a drop when the target is unencodable.
- Adds per-set round-robin replacement, a two-cycle read-modify-write update port and a one-cycle global flush.
- Sits between the BPU next-PC generator (lookup port) and the FTQ commit path (update port).

---
 rtl/ftb_assoc.sv | 255 +++++++++++++++++++++++++
 tb/tb_ftb_assoc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ftb_assoc.sv
// Set-associative fetch target buffer: one-cycle registered lookup, two-cycle
// read-modify-write update with per-set round-robin replacement, and a one-cycle global flush.
module ftb_assoc #(
  parameter int XLEN          = 64,
  parameter int SETS          = 256,
  parameter int WAYS          = 4,
  parameter int TAG_W         = 16,
  parameter int TARGET_W      = 12,
  parameter int FALLTHRU_W    = 5,
  parameter int CNT_W         = 2,
  parameter int PREDICT_BYTES = 32,
  parameter int TYPE_W        = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_lookup_req,
  input  logic [XLEN-1:0]          i_lookup_pc,
  output logic                     o_lookup_vld,
  output logic                     o_lookup_hit,
  output logic [$clog2(WAYS)-1:0]  o_lookup_way,
  output logic                     o_lookup_taken,
  output logic [XLEN-1:0]          o_lookup_npc,
  output logic [TYPE_W-1:0]        o_lookup_type,
  output logic [CNT_W-1:0]         o_lookup_counter,
  input  logic                     i_update_req,
  output logic                     o_update_rdy,
  input  logic [XLEN-1:0]          i_update_pc,
  input  logic                     i_update_taken,
  input  logic [XLEN-1:0]          i_update_target,
  input  logic [XLEN-1:0]          i_update_fallthru,
  input  logic [TYPE_W-1:0]        i_update_type,
  output logic                     o_update_drop,
  input  logic                     i_flush
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int HI_T  = XLEN - TARGET_W - 1;
  localparam int HI_F  = XLEN - FALLTHRU_W - 1;
  localparam logic [1:0] ENC_FIT = 2'd0, ENC_OVF = 2'd1, ENC_UDF = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_TAKEN = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK  = CNT_TAKEN - CNT_W'(1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_mem [SETS][WAYS];
  logic [TARGET_W-1:0]   tgt_mem [SETS][WAYS];
  logic [1:0]            enc_mem [SETS][WAYS];
  logic [FALLTHRU_W-1:0] ft_mem  [SETS][WAYS];
  logic                  cry_mem [SETS][WAYS];
  logic [TYPE_W-1:0]     typ_mem [SETS][WAYS];
  logic [CNT_W-1:0]      cnt_mem [SETS][WAYS];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [WAYS-1:0]  l_match;
  logic             l_hit;
  logic [WAY_W-1:0] l_way;
  logic [HI_T-1:0]  l_hi_t, l_hi_dec;
  logic [HI_F-1:0]  l_hi_f;
  logic [CNT_W-1:0] l_cnt;
  logic [XLEN-1:0]  l_tgt_npc, l_ft_npc;

  assign l_idx = i_lookup_pc[IDX_W:1];
  assign l_tag = i_lookup_pc[IDX_W+TAG_W:IDX_W+1];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lmatch
    assign l_match[gi] = valid_q[l_idx][gi] && (tag_mem[l_idx][gi] == l_tag);
  end

  always_comb begin
    l_hit = |l_match;
    l_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (l_match[w]) l_way = WAY_W'(w);
  end

  assign l_hi_t = i_lookup_pc[XLEN-1:TARGET_W+1];
  assign l_hi_f = i_lookup_pc[XLEN-1:FALLTHRU_W+1];
  assign l_cnt  = cnt_mem[l_idx][l_way];

  always_comb begin
    case (enc_mem[l_idx][l_way])
      ENC_OVF: l_hi_dec = l_hi_t + HI_T'(1);
      ENC_UDF: l_hi_dec = l_hi_t - HI_T'(1);
      default: l_hi_dec = l_hi_t;
    endcase
  end

  assign l_tgt_npc = {l_hi_dec, tgt_mem[l_idx][l_way], 1'b0};
  assign l_ft_npc  = {l_hi_f + HI_F'(cry_mem[l_idx][l_way]), ft_mem[l_idx][l_way], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lookup_vld     <= 1'b0;
      o_lookup_hit     <= 1'b0;
      o_lookup_way     <= '0;
      o_lookup_taken   <= 1'b0;
      o_lookup_npc     <= '0;
      o_lookup_type    <= '0;
      o_lookup_counter <= '0;
    end else begin
      o_lookup_vld <= i_lookup_req;
      if (i_lookup_req) begin
        o_lookup_hit <= l_hit;
        if (l_hit) begin
          o_lookup_way     <= l_way;
          o_lookup_taken   <= l_cnt[CNT_W-1];
          o_lookup_counter <= l_cnt;
          o_lookup_type    <= typ_mem[l_idx][l_way];
          o_lookup_npc     <= l_cnt[CNT_W-1] ? l_tgt_npc : l_ft_npc;
        end else begin
          o_lookup_way     <= '0;
          o_lookup_taken   <= 1'b0;
          o_lookup_counter <= '0;
          o_lookup_type    <= '0;
          o_lookup_npc     <= i_lookup_pc + XLEN'(PREDICT_BYTES);
        end
      end
    end
  end

  // ---------------- update: encode at accept, write in WRITE ----------------
  state_t                state_q;
  logic                  rdy_q, u_taken, u_carry, u_drop;
  logic [XLEN-1:0]       u_pc;
  logic [TARGET_W-1:0]   u_tgt;
  logic [FALLTHRU_W-1:0] u_ft;
  logic [1:0]            u_enc;
  logic [TYPE_W-1:0]     u_type;

  logic            accept;
  logic [HI_T-1:0] e_pc_hi_t, e_tg_hi;
  logic [HI_F-1:0] e_pc_hi_f, e_ft_hi;
  logic [1:0]      e_enc;
  logic            e_bad_t, e_carry, e_bad_f;

  assign accept    = i_update_req && (state_q == S_IDLE) && !i_flush;
  assign e_pc_hi_t = i_update_pc[XLEN-1:TARGET_W+1];
  assign e_tg_hi   = i_update_target[XLEN-1:TARGET_W+1];
  assign e_pc_hi_f = i_update_pc[XLEN-1:FALLTHRU_W+1];
  assign e_ft_hi   = i_update_fallthru[XLEN-1:FALLTHRU_W+1];

  always_comb begin
    e_enc   = ENC_FIT;
    e_bad_t = 1'b0;
    if (e_tg_hi == e_pc_hi_t)                e_enc = ENC_FIT;
    else if (e_tg_hi == e_pc_hi_t + HI_T'(1)) e_enc = ENC_OVF;
    else if (e_tg_hi == e_pc_hi_t - HI_T'(1)) e_enc = ENC_UDF;
    else                                      e_bad_t = 1'b1;
    e_carry = (e_ft_hi != e_pc_hi_f);
    e_bad_f = e_carry && (e_ft_hi != e_pc_hi_f + HI_F'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b1;
      u_pc    <= '0;
      u_taken <= 1'b0;
      u_tgt   <= '0;
      u_enc   <= ENC_FIT;
      u_ft    <= '0;
      u_carry <= 1'b0;
      u_type  <= '0;
      u_drop  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_q <= S_WRITE;
          rdy_q   <= 1'b0;
          u_pc    <= i_update_pc;
          u_taken <= i_update_taken;
          u_tgt   <= i_update_target[TARGET_W:1];
          u_enc   <= e_enc;
          u_ft    <= i_update_fallthru[FALLTHRU_W:1];
          u_carry <= e_carry;
          u_type  <= i_update_type;
          u_drop  <= e_bad_t | e_bad_f;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_update_rdy  = rdy_q;
  assign o_update_drop = (state_q == S_WRITE) && u_drop && !i_flush;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WAYS-1:0]  w_match, w_inv;
  logic             w_hit, do_write;
  logic [WAY_W-1:0] w_hit_way, w_inv_way, w_way;
  logic [CNT_W-1:0] w_old_cnt, w_new_cnt;

  assign w_idx = u_pc[IDX_W:1];
  assign w_tag = u_pc[IDX_W+TAG_W:IDX_W+1];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_wmatch
    assign w_match[gi] = valid_q[w_idx][gi] && (tag_mem[w_idx][gi] == w_tag);
    assign w_inv[gi]   = !valid_q[w_idx][gi];
  end

  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) w_hit_way = WAY_W'(w);
      if (w_inv[w])   w_inv_way = WAY_W'(w);
    end
    w_hit = |w_match;
    w_way = w_hit ? w_hit_way : (|w_inv) ? w_inv_way : rr_q[w_idx];
  end

  assign w_old_cnt = cnt_mem[w_idx][w_hit_way];

  always_comb begin
    if (!w_hit)               w_new_cnt = u_taken ? CNT_TAKEN : CNT_WEAK;
    else if (u_taken)         w_new_cnt = (w_old_cnt == CNT_MAX) ? w_old_cnt : w_old_cnt + CNT_W'(1);
    else                      w_new_cnt = (w_old_cnt == '0) ? w_old_cnt : w_old_cnt - CNT_W'(1);
  end

  assign do_write = (state_q == S_WRITE) && !u_drop && !i_flush;

  // Round-robin pointer only advances when it actually chose the victim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (do_write) begin
      valid_q[w_idx][w_way] <= 1'b1;
      if (!w_hit && !(|w_inv)) rr_q[w_idx] <= rr_q[w_idx] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      tag_mem[w_idx][w_way] <= w_tag;
      tgt_mem[w_idx][w_way] <= u_tgt;
      enc_mem[w_idx][w_way] <= u_enc;
      ft_mem[w_idx][w_way]  <= u_ft;
      cry_mem[w_idx][w_way] <= u_carry;
      typ_mem[w_idx][w_way] <= u_type;
      cnt_mem[w_idx][w_way] <= w_new_cnt;
    end
  end
endmodule

// File: tb/tb_ftb_assoc.sv
// Directed scoreboard bench for ftb_assoc: lookups push expected results, a monitor pops and compares.
module tb_ftb_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_lookup_req = 1'b0;
  logic [63:0] i_lookup_pc = '0;
  logic        o_lookup_vld, o_lookup_hit, o_lookup_taken;
  logic [1:0]  o_lookup_way, o_lookup_counter;
  logic [63:0] o_lookup_npc;
  logic [2:0]  o_lookup_type;
  logic        i_update_req = 1'b0;
  logic        o_update_rdy;
  logic [63:0] i_update_pc = '0, i_update_target = '0, i_update_fallthru = '0;
  logic        i_update_taken = 1'b0;
  logic [2:0]  i_update_type = '0;
  logic        o_update_drop;
  logic        i_flush = 1'b0;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic        taken;
    logic [1:0]  cnt;
    logic [2:0]  typ;
    logic [63:0] npc;
  } res_t;

  res_t exp_q[$];

  ftb_assoc dut (
    .clk(clk), .rst(rst),
    .i_lookup_req(i_lookup_req), .i_lookup_pc(i_lookup_pc),
    .o_lookup_vld(o_lookup_vld), .o_lookup_hit(o_lookup_hit), .o_lookup_way(o_lookup_way),
    .o_lookup_taken(o_lookup_taken), .o_lookup_npc(o_lookup_npc), .o_lookup_type(o_lookup_type),
    .o_lookup_counter(o_lookup_counter),
    .i_update_req(i_update_req), .o_update_rdy(o_update_rdy), .i_update_pc(i_update_pc),
    .i_update_taken(i_update_taken), .i_update_target(i_update_target),
    .i_update_fallthru(i_update_fallthru), .i_update_type(i_update_type),
    .o_update_drop(o_update_drop), .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one line per observed lookup result.
  always @(negedge clk) begin
    if (!rst && o_lookup_vld) begin
      res_t act, e;
      act.hit = o_lookup_hit;   act.way = o_lookup_way;   act.taken = o_lookup_taken;
      act.cnt = o_lookup_counter; act.typ = o_lookup_type; act.npc = o_lookup_npc;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL lookup_unexpected: got vld=1 npc=%h, required no result", act.npc);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL lookup: got hit=%0d way=%0d taken=%0d cnt=%0d type=%0d npc=%h, required hit=%0d way=%0d taken=%0d cnt=%0d type=%0d npc=%h",
                   act.hit, act.way, act.taken, act.cnt, act.typ, act.npc,
                   e.hit, e.way, e.taken, e.cnt, e.typ, e.npc);
        end else begin
          $display("lookup ok: hit=%0d way=%0d cnt=%0d npc=%h", act.hit, act.way, act.cnt, act.npc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic res_t miss(input logic [63:0] pc);
    res_t r;
    r = '0;
    r.npc = pc + 64'd32;
    return r;
  endfunction

  function automatic res_t hitr(input logic [1:0] way, input logic [1:0] cnt,
                                input logic [2:0] typ, input logic [63:0] npc);
    res_t r;
    r.hit = 1'b1; r.way = way; r.cnt = cnt; r.taken = cnt[1]; r.typ = typ; r.npc = npc;
    return r;
  endfunction

  task automatic do_lookup(input logic [63:0] pc, input res_t e);
    @(negedge clk);
    i_lookup_req = 1'b1;
    i_lookup_pc  = pc;
    exp_q.push_back(e);
    @(negedge clk);
    i_lookup_req = 1'b0;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                           input logic [63:0] ft, input logic [2:0] ty,
                           input logic exp_drop, input logic flush_w);
    @(negedge clk);
    chk("rdy_idle", 64'(o_update_rdy), 64'd1);
    i_update_req = 1'b1; i_update_pc = pc; i_update_taken = tk;
    i_update_target = tgt; i_update_fallthru = ft; i_update_type = ty;
    @(negedge clk);
    i_update_req = 1'b0;
    if (flush_w) i_flush = 1'b1;
    chk("rdy_busy", 64'(o_update_rdy), 64'd0);
    chk("drop_write", 64'(o_update_drop), 64'(exp_drop));
    $display("update pc=%h taken=%0d target=%h drop_expected=%0d flush=%0d", pc, tk, tgt, exp_drop, flush_w);
    @(negedge clk);
    i_flush = 1'b0;
    chk("rdy_after", 64'(o_update_rdy), 64'd1);
    chk("drop_after", 64'(o_update_drop), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_vld", 64'(o_lookup_vld), 64'd0);
    chk("reset_hit", 64'(o_lookup_hit), 64'd0);
    chk("reset_npc", o_lookup_npc, 64'd0);
    chk("reset_rdy", 64'(o_update_rdy), 64'd1);
    chk("reset_drop", 64'(o_update_drop), 64'd0);

    do_lookup(64'h8000_0000, miss(64'h8000_0000));

    // Allocate, then walk the counter down to saturation.
    do_update(64'h8000_0000, 1'b1, 64'h8000_0100, 64'h8000_0010, 3'd1, 1'b0, 1'b0);
    do_lookup(64'h8000_0000, hitr(2'd0, 2'd2, 3'd1, 64'h8000_0100));
    do_update(64'h8000_0000, 1'b0, 64'h8000_0100, 64'h8000_0010, 3'd1, 1'b0, 1'b0);
    do_lookup(64'h8000_0000, hitr(2'd0, 2'd1, 3'd1, 64'h8000_0010));
    do_update(64'h8000_0000, 1'b0, 64'h8000_0100, 64'h8000_0010, 3'd1, 1'b0, 1'b0);
    do_lookup(64'h8000_0000, hitr(2'd0, 2'd0, 3'd1, 64'h8000_0010));
    do_update(64'h8000_0000, 1'b0, 64'h8000_0100, 64'h8000_0010, 3'd1, 1'b0, 1'b0);
    do_lookup(64'h8000_0000, hitr(2'd0, 2'd0, 3'd1, 64'h8000_0010));

    // OVF target, unencodable drop, then fallthrough with carry.
    do_update(64'h8000_1FF0, 1'b1, 64'h8000_2010, 64'h8000_2000, 3'd2, 1'b0, 1'b0);
    do_lookup(64'h8000_1FF0, hitr(2'd0, 2'd2, 3'd2, 64'h8000_2010));
    do_update(64'h8000_1FF0, 1'b0, 64'h8010_0000, 64'h8000_2000, 3'd2, 1'b1, 1'b0);
    do_lookup(64'h8000_1FF0, hitr(2'd0, 2'd2, 3'd2, 64'h8000_2010));
    do_update(64'h8000_1FF0, 1'b0, 64'h8000_2010, 64'h8000_2000, 3'd2, 1'b0, 1'b0);
    do_lookup(64'h8000_1FF0, hitr(2'd0, 2'd1, 3'd2, 64'h8000_2000));

    // UDF target.
    do_update(64'h8000_2010, 1'b1, 64'h8000_1FF0, 64'h8000_2020, 3'd4, 1'b0, 1'b0);
    do_lookup(64'h8000_2010, hitr(2'd0, 2'd2, 3'd4, 64'h8000_1FF0));

    // Same-set conflicts: fill ways, evict way 0 via round-robin, then way 1.
    for (int k = 0; k < 5; k++)
      do_update(64'h8000_0000 + 64'(k) * 64'h200, 1'b1, 64'h8000_0100 + 64'(k) * 64'h200,
                64'h8000_0010 + 64'(k) * 64'h200, 3'd3, 1'b0, 1'b0);
    do_lookup(64'h8000_0000, miss(64'h8000_0000));
    do_lookup(64'h8000_0800, hitr(2'd0, 2'd2, 3'd3, 64'h8000_0900));
    do_update(64'h8000_0A00, 1'b1, 64'h8000_0B00, 64'h8000_0A10, 3'd3, 1'b0, 1'b0);
    do_lookup(64'h8000_0A00, hitr(2'd1, 2'd2, 3'd3, 64'h8000_0B00));
    do_lookup(64'h8000_0200, miss(64'h8000_0200));
    do_lookup(64'h8000_0400, hitr(2'd2, 2'd2, 3'd3, 64'h8000_0500));

    // Flush during the WRITE cycle.
    do_update(64'h8000_0C00, 1'b1, 64'h8000_0D00, 64'h8000_0C10, 3'd3, 1'b0, 1'b1);
    do_lookup(64'h8000_0C00, miss(64'h8000_0C00));
    do_lookup(64'h8000_0800, miss(64'h8000_0800));
    do_lookup(64'h8000_1FF0, miss(64'h8000_1FF0));
    do_lookup(64'h8000_2010, miss(64'h8000_2010));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
